// File: rtl/sum_slice_ctrl.sv
// Sequencer for a word-serial slice adder: frames operations, owns the inter-slice carry
// and buffers one sum slice. Optional abort input enabled by SUM_SLICE_CTRL_ABORT_EN.
module sum_slice_ctrl #(
    parameter int W     = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
`ifdef SUM_SLICE_CTRL_ABORT_EN
    input  logic             abort,
`endif
    input  logic             start,
    input  logic [CNT_W-1:0] len_m1,
    output logic             busy,
    output logic             done,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     a_in,
    input  logic [W-1:0]     b_in,
    output logic [W-1:0]     add_a,
    output logic [W-1:0]     add_b,
    output logic             add_cin,
    input  logic [W-1:0]     add_s,
    input  logic             add_cout,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_data,
    output logic             out_last
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic             carry_q, carry_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] len_q, len_d;
    logic             out_valid_q, out_valid_d;
    logic [W-1:0]     out_data_q, out_data_d;
    logic             out_last_q, out_last_d;
    logic             done_q, done_d;

    logic             accept;
    logic             out_hs;

    // State register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            carry_q     <= 1'b0;
            cnt_q       <= '0;
            len_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            carry_q     <= carry_d;
            cnt_q       <= cnt_d;
            len_q       <= len_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            done_q      <= done_d;
        end
    end

    assign accept = (state_q == S_RUN) && in_valid && in_ready;
    assign out_hs = out_valid_q && out_ready;

    // Next-state and datapath updates
    always_comb begin
        state_d     = state_q;
        carry_d     = carry_q;
        cnt_d       = cnt_q;
        len_d       = len_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        done_d      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    len_d   = len_m1;
                    cnt_d   = '0;
                    carry_d = 1'b0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (out_hs) begin
                    out_valid_d = 1'b0;
                end
                // An accept in the same cycle as a handshake reloads the buffer.
                if (accept) begin
                    out_data_d  = add_s;
                    out_valid_d = 1'b1;
                    out_last_d  = (cnt_q == len_q);
                    carry_d     = add_cout;
                    cnt_d       = cnt_q + CNT_W'(1);
                    if (cnt_q == len_q) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (out_hs && out_last_q) begin
                    out_valid_d = 1'b0;
                    out_last_d  = 1'b0;
                    done_d      = 1'b1;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

`ifdef SUM_SLICE_CTRL_ABORT_EN
        if (abort && (state_q != S_IDLE)) begin
            state_d     = S_IDLE;
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            carry_d     = 1'b0;
            done_d      = 1'b0;
        end
`endif
    end

    // Outputs
    always_comb begin
        busy     = (state_q == S_RUN) || (state_q == S_DRAIN);
        in_ready = (state_q == S_RUN) && (!out_valid_q || out_ready);
    end

    assign done      = done_q;
    assign add_a     = a_in;
    assign add_b     = b_in;
    assign add_cin   = carry_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;

endmodule

// File: tb/tb_sum_slice_ctrl.sv
// Directed self-checking bench for sum_slice_ctrl with a behavioural slice adder attached.
module tb_sum_slice_ctrl;

    localparam int W     = 8;
    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst;
`ifdef SUM_SLICE_CTRL_ABORT_EN
    logic             abort;
`endif
    logic             start;
    logic [CNT_W-1:0] len_m1;
    logic             busy, done;
    logic             in_valid, in_ready;
    logic [W-1:0]     a_in, b_in;
    logic [W-1:0]     add_a, add_b, add_s;
    logic             add_cin, add_cout;
    logic             out_valid, out_ready, out_last;
    logic [W-1:0]     out_data;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    // External combinational slice adder
    assign {add_cout, add_s} = {1'b0, add_a} + {1'b0, add_b} + {{W{1'b0}}, add_cin};

    sum_slice_ctrl #(.W(W), .CNT_W(CNT_W)) dut (
        .clk      (clk),
        .rst      (rst),
`ifdef SUM_SLICE_CTRL_ABORT_EN
        .abort    (abort),
`endif
        .start    (start),
        .len_m1   (len_m1),
        .busy     (busy),
        .done     (done),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a_in     (a_in),
        .b_in     (b_in),
        .add_a    (add_a),
        .add_b    (add_b),
        .add_cin  (add_cin),
        .add_s    (add_s),
        .add_cout (add_cout),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_last (out_last)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s = 0x%0h", tag, got);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_op(input logic [CNT_W-1:0] n);
        start  = 1'b1;
        len_m1 = n;
        step();
        start  = 1'b0;
    endtask

    task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b);
        in_valid = 1'b1;
        a_in     = a;
        b_in     = b;
        #1;
    endtask

    int  beats;
    bit  done_seen;

    initial begin
        rst = 1'b0; start = 1'b0; len_m1 = '0; in_valid = 1'b0;
        a_in = '0; b_in = '0; out_ready = 1'b1;
`ifdef SUM_SLICE_CTRL_ABORT_EN
        abort = 1'b0;
`endif
        step(); step();
        chk("rst_busy", busy, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_done", done, 0);
        chk("rst_add_cin", add_cin, 0);
        chk("rst_in_ready", in_ready, 0);
        rst = 1'b1;
        step();

        // Two-slice add: FF+01 then 00+00+carry
        start_op(1);
        chk("t1_busy", busy, 1);
        drive(8'hFF, 8'h01);
        chk("t1_in_ready0", in_ready, 1);
        chk("t1_cin0", add_cin, 0);
        chk("t1_add_a", add_a, 8'hFF);
        step();
        chk("t1_data0", out_data, 8'h00);
        chk("t1_last0", out_last, 0);
        chk("t1_valid0", out_valid, 1);
        drive(8'h00, 8'h00);
        chk("t1_cin1", add_cin, 1);
        chk("t1_in_ready1", in_ready, 1);
        step();
        chk("t1_data1", out_data, 8'h01);
        chk("t1_last1", out_last, 1);
        in_valid = 1'b0;
        #1;
        chk("t1_drain_in_ready", in_ready, 0);
        chk("t1_drain_done", done, 0);
        step();
        chk("t1_done", done, 1);
        chk("t1_done_busy", busy, 0);
        chk("t1_done_valid", out_valid, 0);
        step();
        chk("t1_done_clear", done, 0);

        // Carry isolation: op1 leaves carry=1, op2 must start with carry 0
        start_op(0);
        drive(8'hFF, 8'h01);
        step();
        chk("t2_op1_data", out_data, 8'h00);
        chk("t2_op1_last", out_last, 1);
        chk("t2_op1_carry", add_cin, 1);
        in_valid = 1'b0;
        step();
        chk("t2_op1_done", done, 1);
        start_op(0);
        chk("t2_op2_busy", busy, 1);
        chk("t2_op2_cin", add_cin, 0);
        drive(8'h00, 8'h00);
        step();
        chk("t2_op2_data", out_data, 8'h00);
        in_valid = 1'b0;
        step();
        chk("t2_op2_done", done, 1);
        step();

        // Back-pressure: 80+80 chain with a three-cycle stall after the first beat
        start_op(3);
        out_ready = 1'b0;
        drive(8'h80, 8'h80);
        chk("t3_in_ready_empty", in_ready, 1);
        step();
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("t3_stall%0d_data", i), out_data, 8'h00);
            chk($sformatf("t3_stall%0d_in_ready", i), in_ready, 0);
            step();
        end
        chk("t3_hold_valid", out_valid, 1);
        out_ready = 1'b1;
        #1;
        chk("t3_resume_in_ready", in_ready, 1);
        chk("t3_resume_cin", add_cin, 1);
        step();
        chk("t3_data1", out_data, 8'h01);
        chk("t3_last1", out_last, 0);
        step();
        chk("t3_data2", out_data, 8'h01);
        chk("t3_last2", out_last, 0);
        step();
        chk("t3_data3", out_data, 8'h01);
        chk("t3_last3", out_last, 1);
        in_valid = 1'b0;
        step();
        chk("t3_done", done, 1);
        step();

        // Start while busy is ignored; start in the done cycle is accepted
        start_op(2);
        beats = 0;
        done_seen = 1'b0;
        drive(8'h01, 8'h02);
        for (int cyc = 0; cyc < 20; cyc++) begin
            if (out_valid && out_ready) beats++;
            step();
            if (done) begin
                done_seen = 1'b1;
                break;
            end
            start  = (cyc == 1);
            len_m1 = 5;
            #1;
        end
        start = 1'b0;
        chk("t4_done_seen", done_seen, 1);
        chk("t4_beats", beats, 3);
        start_op(0);
        chk("t4_restart_busy", busy, 1);
        drive(8'h05, 8'h06);
        step();
        chk("t4_restart_data", out_data, 8'h0B);
        chk("t4_restart_last", out_last, 1);
        in_valid = 1'b0;
        step();
        chk("t4_restart_done", done, 1);
        step();

        // Reset mid-operation
        start_op(3);
        drive(8'hFF, 8'h01);
        step();
        step();
        rst = 1'b0;
        in_valid = 1'b0;
        step();
        chk("t5_valid", out_valid, 0);
        chk("t5_busy", busy, 0);
        chk("t5_cin", add_cin, 0);
        chk("t5_done", done, 0);
        rst = 1'b1;
        step();
        chk("t5_done_after", done, 0);
        start_op(0);
        drive(8'h03, 8'h04);
        step();
        chk("t5_next_data", out_data, 8'h07);
        in_valid = 1'b0;
        step();
        chk("t5_next_done", done, 1);
        step();

`ifdef SUM_SLICE_CTRL_ABORT_EN
        // Abort with an accept pending
        start_op(3);
        drive(8'hFF, 8'h01);
        step();
        abort = 1'b1;
        #1;
        step();
        abort = 1'b0;
        in_valid = 1'b0;
        chk("t6_busy", busy, 0);
        chk("t6_valid", out_valid, 0);
        chk("t6_cin", add_cin, 0);
        chk("t6_done", done, 0);
        step();
        chk("t6_done_after", done, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/sum_slice_ctrl.md
Name: sum_slice_ctrl

Overview:
Sequencer for the word-serial slice adder: streams one W-bit slice of operands a/b per accepted beat through an external combinational slice adder. It owns the inter-slice carry register and clears it at every operation start, so back-to-back additions never leak carry. It frames each operation with start/busy/done, applies valid/ready back-pressure on operand input and sum output, and buffers one output slice.

Parameters:
W, 8, slice width in bits (operand, sum and adder width)
CNT_W, 16, width of the slice counter; one operation covers up to 2^CNT_W slices

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  reset, synchronous, active-low
start  in  1  begin an operation; sampled only in IDLE
len_m1  in  CNT_W  slice count minus 1; sampled with start
busy  out  1  high in RUN or DRAIN
done  out  1  one-cycle pulse on operation completion
in_valid  in  1  a_in/b_in hold a valid slice pair
in_ready  out  1  controller accepts the slice pair this cycle
a_in  in  W  operand A slice, LS slice first
b_in  in  W  operand B slice, LS slice first
add_a  out  W  to adder: equals a_in (combinational)
add_b  out  W  to adder: equals b_in (combinational)
add_cin  out  1  to adder: current carry register
add_s  in  W  from adder: slice sum
add_cout  in  1  from adder: slice carry out
out_valid  out  1  out_data holds a sum slice
out_ready  in  1  sink accepts out_data this cycle
out_data  out  W  registered sum slice
out_last  out  1  qualifies out_data as final slice of the operation

Behaviour:
- Reset (rst==0 at clock edge): state=IDLE, carry=0, cnt=0, len=0, out_valid=0, out_data=0, out_last=0, done=0. Reset mid-operation discards everything, including the buffered slice; no done.
- States: IDLE, RUN, DRAIN.
- IDLE: busy=0, in_ready=0. On start: len<=len_m1, cnt<=0, carry<=0, state<=RUN. len_m1=0 means one slice.
- RUN: busy=1; in_ready = !out_valid || out_ready (one-deep buffer, full-throughput pass-through).
- Accept = in_valid && in_ready: out_data<=add_s, out_valid<=1, out_last<=(cnt==len), carry<=add_cout, cnt<=cnt+1. If cnt==len, state<=DRAIN.
- Output handshake out_valid && out_ready with no same-cycle accept: out_valid<=0. A same-cycle accept and output handshake reloads the buffer (out_valid stays 1).
- DRAIN: in_ready=0. On output handshake with out_last=1: out_valid<=0, out_last<=0, done<=1 for the next cycle, state<=IDLE.
- done is registered and high in the first IDLE cycle. A start in that cycle is accepted.
- start outside IDLE is ignored; len_m1 is ignored outside IDLE.
- add_cin reflects the carry register in every state. Carry changes only on accept, on start (clear) and on reset.
- cnt does not wrap within an operation. len_m1 = 2^CNT_W-1 runs the full counter range and ends at cnt==len.
- Latency: slice accepted at edge k appears on out_data after edge k; minimum operation time is len_m1+2 cycles, start to done.
- out_data and out_last hold stable while out_valid && !out_ready.

Optional Feature:
SUM_SLICE_CTRL_ABORT_EN: adds input abort (1 bit).
- With the macro: abort=1 in RUN or DRAIN forces state<=IDLE, out_valid<=0, out_last<=0, carry<=0 at the next edge. No done pulse. Abort has priority over a same-cycle accept and a same-cycle output handshake. Abort in IDLE has no effect.
- Without the macro: the port does not exist and operations run only to completion or reset.

Test Plan:
- Two-slice add: len_m1=1, a={0xFF,0x00}, b={0x01,0x00}, out_ready=1 -> out_data 0x00 then 0x01 with out_last on second beat; add_cin=1 during second accept; done one cycle after last handshake.
- Carry isolation: op1 len_m1=0, a=0xFF, b=0x01 -> 0x00 (carry 1); then op2 len_m1=0, a=0x00, b=0x00 -> out_data 0x00, add_cin=0.
- Back-pressure: len_m1=3, all slices a=0x80, b=0x80, out_ready low for 3 cycles after first beat -> in_ready low while buffer full; outputs 0x00,0x01,0x01,0x01, data stable while stalled, no slice lost or duplicated.
- Start while busy: pulse start with len_m1=5 during a len_m1=2 operation -> ignored; exactly 3 output beats; start in the done cycle launches the next operation.
- Reset mid-operation: rst=0 after 2 of 4 slices accepted -> next cycle out_valid=0, busy=0, add_cin=0, no done; a subsequent op runs normally.
- Abort (SUM_SLICE_CTRL_ABORT_EN): abort with an accept pending in RUN -> next cycle IDLE, out_valid=0, carry=0, no done; without the macro, elaborates with no abort port.
